// File: rtl/score_event_gen.sv
// Score event generator: converts landing/bonus events into single-cycle score pulses.
// Latency: an event at cycle N drives pending and, if the drain is free, increase at edge N+1.
// Backpressure: none upstream; credits queue in a saturating counter, drained one pulse per PULSE_GAP cycles.
module score_event_gen #(
  parameter int LAND_POINTS  = 1,
  parameter int BONUS_POINTS = 5,
  parameter int PEND_W       = 6,
  parameter int PULSE_GAP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              game_en,
  input  logic              landed,
  input  logic [3:0]        platform_id,
  input  logic              bonus_hit,
  output logic              increase,
  output logic [PEND_W-1:0] pending,
  output logic              busy
);

  // Sum width leaves headroom for pending + both awards before saturation.
  localparam int SW    = PEND_W + 2;
  localparam int GAP_W = (PULSE_GAP > 2) ? $clog2(PULSE_GAP) : 1;

  typedef logic [SW-1:0]    sum_t;
  typedef logic [GAP_W-1:0] gap_t;

  localparam sum_t             LAND_C   = sum_t'(LAND_POINTS);
  localparam sum_t             BONUS_C  = sum_t'(BONUS_POINTS);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam gap_t             GAP_LOAD = gap_t'(PULSE_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              increase_q, increase_d;
  gap_t              gap_q, gap_d;
  logic [3:0]        last_id_q, last_id_d;
  logic              landed_d_q;

  logic              land_ev;
  logic              active;
  logic              land_award;
  logic              bonus_award;
  sum_t              avail;
  sum_t              sum_nxt;
  logic              issue;

  assign land_ev = landed && !landed_d_q;

  // State, credit and pulse registers; reset clears everything including the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      increase_q <= 1'b0;
      gap_q      <= '0;
      last_id_q  <= 4'd0;
      landed_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      increase_q <= increase_d;
      gap_q      <= gap_d;
      last_id_q  <= last_id_d;
      landed_d_q <= landed;
    end
  end

  // Next-state, awards and drain; credits arriving in a launch cycle count in the same cycle.
  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    pending_d   = pending_q;
    increase_d  = 1'b0;
    gap_d       = (gap_q != '0) ? gap_q - gap_t'(1) : gap_q;
    active      = 1'b0;
    land_award  = 1'b0;
    bonus_award = 1'b0;
    avail       = '0;
    sum_nxt     = '0;
    issue       = 1'b0;

    case (state_q)
      S_IDLE: begin
        pending_d = '0;
        if (game_en) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!game_en) begin
          state_d   = S_IDLE;
          pending_d = '0;
        end else begin
          active      = 1'b1;
          bonus_award = bonus_hit;
          // First touchdown only establishes the reference platform.
          if (land_ev) begin
            last_id_d = platform_id;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!game_en) begin
          state_d   = S_IDLE;
          pending_d = '0;
        end else begin
          active      = 1'b1;
          bonus_award = bonus_hit;
          // Re-landing on the same platform is not progress.
          if (land_ev && (platform_id != last_id_q)) begin
            land_award = 1'b1;
            last_id_d  = platform_id;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        pending_d = '0;
      end
    endcase

    if (active) begin
      avail = {2'b00, pending_q}
            + (land_award  ? LAND_C  : sum_t'(0))
            + (bonus_award ? BONUS_C : sum_t'(0));
      issue   = (avail != '0) && (gap_q == '0);
      sum_nxt = avail - (issue ? sum_t'(1) : sum_t'(0));
      pending_d  = (sum_nxt > {2'b00, PEND_MAX}) ? PEND_MAX : sum_nxt[PEND_W-1:0];
      increase_d = issue;
      if (issue) gap_d = GAP_LOAD;
    end
  end

  assign increase = increase_q;
  assign pending  = pending_q;
  assign busy     = (pending_q != '0) || (gap_q != '0);

endmodule

// File: tb/tb_score_event_gen.sv
// Directed bench for score_event_gen: landing/bonus scoring, drain spacing, saturation, disable and async reset.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled in the same window.
// Pulses are counted on the falling edge so totals are independent of the stimulus process.
module tb_score_event_gen;

  logic       clk;
  logic       rst_n;
  logic       game_en;
  logic       landed;
  logic [3:0] platform_id;
  logic       bonus_hit;
  logic       increase;
  logic [5:0] pending;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int dbl_cnt = 0;
  logic prev_inc = 1'b0;

  score_event_gen #(
    .LAND_POINTS (1),
    .BONUS_POINTS(5),
    .PEND_W      (6),
    .PULSE_GAP   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_en    (game_en),
    .landed     (landed),
    .platform_id(platform_id),
    .bonus_hit  (bonus_hit),
    .increase   (increase),
    .pending    (pending),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulses and flag any pulse longer than one cycle.
  always @(negedge clk) begin
    if (increase) begin
      pulse_cnt <= pulse_cnt + 1;
      if (prev_inc) dbl_cnt <= dbl_cnt + 1;
    end
    prev_inc <= increase;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int cnt0;
  int cnt1;
  int max_pend;

  initial begin
    rst_n = 1'b0;
    game_en = 1'b0;
    landed = 1'b0;
    platform_id = 4'd0;
    bonus_hit = 1'b0;
    steps(2);
    check_eq("rst_increase", int'(increase), 0);
    check_eq("rst_pending", int'(pending), 0);
    check_eq("rst_busy", int'(busy), 0);

    // First landing in ARMED only records the platform.
    rst_n = 1'b1;
    game_en = 1'b1;
    steps(2);
    landed = 1'b1;
    platform_id = 4'd3;
    step();
    check_eq("first_land_inc", int'(increase), 0);
    check_eq("first_land_pend", int'(pending), 0);
    step();
    landed = 1'b0;
    steps(3);
    check_eq("first_land_pulses", pulse_cnt, 0);
    check_eq("first_land_busy", int'(busy), 0);

    // Landings on 4, 4, 7: the repeat of 4 scores nothing.
    cnt0 = pulse_cnt;
    landed = 1'b1; platform_id = 4'd4; step();
    check_eq("land4_inc", int'(increase), 1);
    check_eq("land4_pend", int'(pending), 0);
    landed = 1'b0; steps(3);
    landed = 1'b1; platform_id = 4'd4; step();
    check_eq("reland4_inc", int'(increase), 0);
    landed = 1'b0; steps(3);
    landed = 1'b1; platform_id = 4'd7; step();
    check_eq("land7_inc", int'(increase), 1);
    landed = 1'b0; steps(3);
    check_eq("run_pulses", pulse_cnt - cnt0, 2);
    // A second landing on 7 proves it became the reference platform.
    landed = 1'b1; platform_id = 4'd7; step();
    landed = 1'b0; steps(3);
    check_eq("reland7_pulses", pulse_cnt - cnt0, 2);

    // Bonus and new platform together: 6 credits, one launched immediately.
    cnt0 = pulse_cnt;
    landed = 1'b1; platform_id = 4'd9; bonus_hit = 1'b1;
    step();
    bonus_hit = 1'b0;
    landed = 1'b0;
    check_eq("combo_inc0", int'(increase), 1);
    check_eq("combo_pend0", int'(pending), 5);
    for (int k = 1; k <= 10; k++) begin
      step();
      check_eq($sformatf("combo_inc%0d", k), int'(increase), (k % 2 == 0) ? 1 : 0);
      check_eq($sformatf("combo_pend%0d", k), int'(pending), 5 - k / 2);
    end
    check_eq("combo_busy_last", int'(busy), 1);
    step();
    check_eq("combo_busy_after", int'(busy), 0);
    check_eq("combo_pulses", pulse_cnt - cnt0, 6);

    // 15 back-to-back bonuses: 8 pulses fire during the burst, pending pins at 63.
    cnt0 = pulse_cnt;
    max_pend = 0;
    bonus_hit = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (int'(pending) > max_pend) max_pend = int'(pending);
    end
    bonus_hit = 1'b0;
    check_eq("sat_pend", int'(pending), 63);
    step();
    check_eq("sat_pend_hold", int'(pending), 63);
    check_eq("sat_max", max_pend, 63);
    cnt1 = pulse_cnt;
    for (int k = 0; k < 300 && busy; k++) step();
    check_eq("sat_drain_done", int'(busy), 0);
    check_eq("sat_drain_pulses", pulse_cnt - cnt1, 63);
    check_eq("sat_total_pulses", pulse_cnt - cnt0, 71);

    // Build pending=10, then disable the game.
    landed = 1'b1; platform_id = 4'd11; bonus_hit = 1'b1;
    step();
    landed = 1'b0;
    check_eq("dis_inc0", int'(increase), 1);
    check_eq("dis_pend0", int'(pending), 5);
    step();
    bonus_hit = 1'b0;
    check_eq("dis_pend1", int'(pending), 10);
    game_en = 1'b0;
    step();
    check_eq("dis_pend", int'(pending), 0);
    check_eq("dis_inc", int'(increase), 0);
    check_eq("dis_busy", int'(busy), 0);
    cnt0 = pulse_cnt;
    bonus_hit = 1'b1; step(); bonus_hit = 1'b0;
    landed = 1'b1; platform_id = 4'd5; step(); landed = 1'b0;
    steps(2);
    check_eq("idle_ignore_pend", int'(pending), 0);
    check_eq("idle_ignore_pulses", pulse_cnt - cnt0, 0);

    // Re-enable: the first landing re-arms without scoring.
    game_en = 1'b1;
    steps(2);
    landed = 1'b1; platform_id = 4'd12; step();
    check_eq("rearm_land_inc", int'(increase), 0);
    check_eq("rearm_land_pend", int'(pending), 0);
    landed = 1'b0; steps(3);
    landed = 1'b1; platform_id = 4'd13; step();
    check_eq("rearm_score_inc", int'(increase), 1);
    landed = 1'b0; steps(3);

    // Asynchronous reset while a pulse is on the wire with credits queued.
    landed = 1'b1; platform_id = 4'd14; bonus_hit = 1'b1;
    step();
    landed = 1'b0; bonus_hit = 1'b0;
    check_eq("pre_rst_inc", int'(increase), 1);
    check_eq("pre_rst_pend", int'(pending), 5);
    rst_n = 1'b0;
    #1;
    check_eq("arst_inc", int'(increase), 0);
    check_eq("arst_pend", int'(pending), 0);
    check_eq("arst_busy", int'(busy), 0);
    steps(2);
    #2;
    rst_n = 1'b1;
    cnt0 = pulse_cnt;
    steps(6);
    check_eq("post_rst_pulses", pulse_cnt - cnt0, 0);
    check_eq("post_rst_pend", int'(pending), 0);
    check_eq("post_rst_busy", int'(busy), 0);

    check_eq("no_long_pulses", dbl_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
